// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_stage: PC owner, ROM address driver and IF/ID register.            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fetch_stage #(
   parameter int               ADDR_W   = 16,
   parameter int               INST_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int               PROG_LEN = 38,
   parameter logic [INST_W-1:0] NOP_WORD = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              branch_en_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   input  logic [INST_W-1:0] inst_i,
   output logic [ADDR_W-1:0] PC_o,
   output logic [INST_W-1:0] if_id_inst_o,
   output logic [ADDR_W-1:0] if_id_pc_o,
   output logic              if_id_valid_o,
   output logic              end_o,
   output logic [15:0]       fetch_cnt_o
);

   // One extra bit so PROG_LEN = 2^ADDR_W means "never off program".
   localparam logic [ADDR_W:0] C_PROG_LEN = (ADDR_W+1)'(PROG_LEN);

   logic [ADDR_W-1:0] r_pc;
   logic [INST_W-1:0] r_inst;
   logic [ADDR_W-1:0] r_if_pc;
   logic              r_valid;
   logic [15:0]       r_cnt;
   logic              w_end;

   assign w_end = ({1'b0, r_pc} >= C_PROG_LEN);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc    <= RESET_PC;
         r_inst  <= NOP_WORD;
         r_if_pc <= '0;
         r_valid <= 1'b0;
         r_cnt   <= '0;
      end else if (branch_en_i) begin
         r_pc    <= branch_target_i;
         r_inst  <= NOP_WORD;
         r_if_pc <= r_pc;
         r_valid <= 1'b0;
      end else if (stall_i) begin
         r_pc    <= r_pc;
      end else if (w_end) begin
         r_inst  <= NOP_WORD;
         r_if_pc <= r_pc;
         r_valid <= 1'b0;
      end else begin
         r_pc    <= r_pc + 1'b1;
         r_inst  <= inst_i;
         r_if_pc <= r_pc;
         r_valid <= 1'b1;
         if (r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
         end
      end
   end

   assign PC_o          = r_pc;
   assign if_id_inst_o  = r_inst;
   assign if_id_pc_o    = r_if_pc;
   assign if_id_valid_o = r_valid;
   assign end_o         = w_end;
   assign fetch_cnt_o   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_stage: directed vector bench for fetch_stage.                   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fetch_stage;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        br;
      logic [15:0] tgt;
      logic [15:0] pc;
      logic [15:0] inst;
      logic [15:0] ipc;
      logic        valid;
      logic        en;
      logic [15:0] cnt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_i = 1'b0;
   logic        branch_en_i = 1'b0;
   logic [15:0] branch_target_i = '0;
   logic [15:0] inst_i;
   logic [15:0] PC_o;
   logic [15:0] if_id_inst_o;
   logic [15:0] if_id_pc_o;
   logic        if_id_valid_o;
   logic        end_o;
   logic [15:0] fetch_cnt_o;

   // Second instance spans the full address space to reach counter saturation and PC wrap.
   logic        rst2 = 1'b1;
   logic        zero1 = 1'b0;
   logic [15:0] zero16 = '0;
   logic [15:0] inst2;
   logic [15:0] pc2;
   logic [15:0] iinst2;
   logic [15:0] ipc2;
   logic        valid2;
   logic        end2;
   logic [15:0] cnt2;

   logic [15:0] rom [0:63];
   vec_t        vq [$];
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   assign inst_i = (PC_o < 16'd38) ? rom[PC_o[5:0]] : 16'hDEAD;
   assign inst2  = pc2 ^ 16'h5A5A;

   fetch_stage dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .branch_en_i(branch_en_i),
      .branch_target_i(branch_target_i), .inst_i(inst_i), .PC_o(PC_o),
      .if_id_inst_o(if_id_inst_o), .if_id_pc_o(if_id_pc_o),
      .if_id_valid_o(if_id_valid_o), .end_o(end_o), .fetch_cnt_o(fetch_cnt_o)
   );

   fetch_stage #(.PROG_LEN(65536)) dut2 (
      .clk(clk), .rst(rst2), .stall_i(zero1), .branch_en_i(zero1),
      .branch_target_i(zero16), .inst_i(inst2), .PC_o(pc2),
      .if_id_inst_o(iinst2), .if_id_pc_o(ipc2),
      .if_id_valid_o(valid2), .end_o(end2), .fetch_cnt_o(cnt2)
   );

   task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic s, input logic b, input logic [15:0] t,
                      input logic [15:0] pc, input logic [15:0] inst, input logic [15:0] ipc,
                      input logic v, input logic e, input logic [15:0] c);
      vec_t x;
      x.rst = r; x.stall = s; x.br = b; x.tgt = t; x.pc = pc; x.inst = inst;
      x.ipc = ipc; x.valid = v; x.en = e; x.cnt = c;
      vq.push_back(x);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 16'h1000 + 16'(i);
      rom[0] = 16'h8800; rom[1] = 16'h8901; rom[4] = 16'h8C04; rom[5] = 16'h0940;

      //   rst s  b  tgt   pc    inst      ipc   v  e  cnt
      add(1, 0, 0, 0,    0,    16'h0000, 0,    0, 0, 0);   // reset
      add(1, 1, 1, 9,    0,    16'h0000, 0,    0, 0, 0);   // reset beats branch/stall
      add(0, 0, 0, 0,    1,    16'h8800, 0,    1, 0, 1);
      add(0, 0, 0, 0,    2,    16'h8901, 1,    1, 0, 2);
      add(0, 0, 0, 0,    3,    16'h1002, 2,    1, 0, 3);
      add(0, 0, 0, 0,    4,    16'h1003, 3,    1, 0, 4);
      add(0, 0, 0, 0,    5,    16'h8C04, 4,    1, 0, 5);
      add(0, 1, 0, 0,    5,    16'h8C04, 4,    1, 0, 5);   // stall x3
      add(0, 1, 0, 0,    5,    16'h8C04, 4,    1, 0, 5);
      add(0, 1, 0, 0,    5,    16'h8C04, 4,    1, 0, 5);
      add(0, 0, 0, 0,    6,    16'h0940, 5,    1, 0, 6);
      add(0, 0, 1, 23,   23,   16'h0000, 6,    0, 0, 6);
      add(0, 0, 1, 24,   24,   16'h0000, 23,   0, 0, 6);
      add(0, 0, 0, 0,    25,   16'h1018, 24,   1, 0, 7);
      add(0, 1, 1, 35,   35,   16'h0000, 25,   0, 0, 7);   // branch beats stall
      add(0, 0, 0, 0,    36,   16'h1023, 35,   1, 0, 8);
      add(0, 0, 0, 0,    37,   16'h1024, 36,   1, 0, 9);
      add(0, 0, 0, 0,    38,   16'h1025, 37,   1, 1, 10);
      add(0, 0, 0, 0,    38,   16'h0000, 38,   0, 1, 10);  // frozen at end
      add(0, 0, 0, 0,    38,   16'h0000, 38,   0, 1, 10);
      add(0, 0, 1, 0,    0,    16'h0000, 38,   0, 0, 10);
      add(0, 0, 0, 0,    1,    16'h8800, 0,    1, 0, 11);
      add(0, 0, 1, 1,    1,    16'h0000, 1,    0, 0, 11);  // branch to self
      add(0, 0, 0, 0,    2,    16'h8901, 1,    1, 0, 12);
      add(0, 0, 1, 100,  100,  16'h0000, 2,    0, 1, 12);  // target off program
      add(0, 1, 0, 0,    100,  16'h0000, 2,    0, 1, 12);
      add(0, 0, 0, 0,    100,  16'h0000, 100,  0, 1, 12);
      add(0, 0, 1, 12,   12,   16'h0000, 100,  0, 0, 12);
      add(0, 1, 0, 0,    12,   16'h0000, 100,  0, 0, 12);
      add(1, 1, 0, 0,    0,    16'h0000, 0,    0, 0, 0);   // reset mid-stall
      add(0, 0, 0, 0,    1,    16'h8800, 0,    1, 0, 1);
      add(0, 0, 0, 0,    2,    16'h8901, 1,    1, 0, 2);

      foreach (vq[i]) begin
         rst = vq[i].rst; stall_i = vq[i].stall;
         branch_en_i = vq[i].br; branch_target_i = vq[i].tgt;
         @(posedge clk); #1;
         chk("pc",    i, PC_o,          vq[i].pc);
         chk("inst",  i, if_id_inst_o,  vq[i].inst);
         chk("ipc",   i, if_id_pc_o,    vq[i].ipc);
         chk("valid", i, {15'd0, if_id_valid_o}, {15'd0, vq[i].valid});
         chk("end",   i, {15'd0, end_o}, {15'd0, vq[i].en});
         chk("cnt",   i, fetch_cnt_o,   vq[i].cnt);
      end

      // Saturation and wrap on the full-address-space instance.
      @(posedge clk); #1;
      rst2 = 1'b0;
      repeat (65534) @(posedge clk);
      #1;
      chk("sat_cnt_pre", 0, cnt2, 16'hFFFE);
      chk("sat_pc_pre",  0, pc2,  16'hFFFE);
      @(posedge clk); #1;
      chk("sat_cnt_max", 1, cnt2, 16'hFFFF);
      chk("sat_pc_max",  1, pc2,  16'hFFFF);
      chk("sat_end",     1, {15'd0, end2}, 16'd0);
      @(posedge clk); #1;
      chk("sat_cnt_hold", 2, cnt2,   16'hFFFF);
      chk("wrap_pc",      2, pc2,    16'h0000);
      chk("wrap_ipc",     2, ipc2,   16'hFFFF);
      chk("wrap_inst",    2, iinst2, 16'hA5A5);
      chk("wrap_valid",   2, {15'd0, valid2}, 16'd1);
      @(posedge clk); #1;
      chk("sat_cnt_hold2", 3, cnt2, 16'hFFFF);
      chk("wrap_pc_next",  3, pc2,  16'h0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
